// File: rtl/controlador_display7seg.sv
// Two-digit decimal driver for a 4-digit multiplexed common-anode 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to darken the tens digit for values 0..9.
module controlador_display7seg #(
  parameter int unsigned REFRESH_COUNT = 100000,
  parameter int unsigned GAP_COUNT     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bin,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned MAX_RG = (REFRESH_COUNT > GAP_COUNT) ? REFRESH_COUNT : GAP_COUNT;
  localparam int unsigned MAX_C  = (MAX_RG > 2) ? MAX_RG : 2;
  localparam int unsigned CW     = $clog2(MAX_C);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_COUNT > 0) ? GAP_COUNT - 1 : 0);

  typedef enum logic [1:0] {S_UNI, S_GAP0, S_DEC, S_GAP1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_valor;

  logic       w_last;
  logic       w_tens;
  logic [3:0] w_units;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    if (r_state == S_UNI || r_state == S_DEC) w_last = (r_cnt == REF_LAST);
    else                                      w_last = (r_cnt == GAP_LAST);
  end

  // valor only loads on entry to S_UNI, so one frame always shows a single sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_UNI;
      r_cnt   <= '0;
      r_valor <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      case (r_state)
        S_UNI:  r_state <= (GAP_COUNT == 0) ? S_DEC : S_GAP0;
        S_GAP0: r_state <= S_DEC;
        S_DEC: begin
          if (GAP_COUNT == 0) begin
            r_state <= S_UNI;
            r_valor <= bin;
          end else begin
            r_state <= S_GAP1;
          end
        end
        default: begin
          r_state <= S_UNI;
          r_valor <= bin;
        end
      endcase
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_tens  = (r_valor >= 4'd10);
    w_units = r_valor - (w_tens ? 4'd10 : 4'd0);
  end

  always_comb begin
    an  = '1;
    seg = '1;
    case (r_state)
      S_UNI: begin
        an  = 4'b1110;
        seg = enc(w_units);
      end
      S_DEC: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (w_tens) begin
          an  = 4'b1101;
          seg = enc(4'd1);
        end
`else
        an  = 4'b1101;
        seg = enc({3'b000, w_tens});
`endif
      end
      default: ;
    endcase
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_controlador_display7seg.sv
// Scoreboard bench: dut_a (REFRESH 4, GAP 2) and dut_b (REFRESH 4, GAP 0), per-cycle expected outputs.
module tb_controlador_display7seg;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] bin_a = 4'd0, bin_b = 4'd9;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b;

  int checks = 0;
  int passes = 0;
  int cyc_na = 0;
  int cyc_nb = 0;

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  controlador_display7seg #(.REFRESH_COUNT(4), .GAP_COUNT(2)) dut_a (
    .clk(clk), .rst(rst_a), .bin(bin_a), .seg(seg_a), .an(an_a), .dp(dp_a)
  );

  controlador_display7seg #(.REFRESH_COUNT(4), .GAP_COUNT(0)) dut_b (
    .clk(clk), .rst(rst_b), .bin(bin_b), .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  // Tens slot expectation, honouring optional leading-zero blanking
  task automatic tens_exp(input int v, output logic [3:0] an_e, output logic [6:0] seg_e);
    an_e  = 4'b1101;
    seg_e = ENC[v / 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 10) begin
      an_e  = 4'b1111;
      seg_e = 7'b1111111;
    end
`endif
  endtask

  task automatic cyc_a(input logic [3:0] an_e, input logic [6:0] seg_e, input logic r, input logic [3:0] b);
    @(posedge clk); #1;
    q_a.push_back({an_e, seg_e, 1'b1});
    rst_a = r;
    bin_a = b;
  endtask

  task automatic cyc_b(input logic [3:0] an_e, input logic [6:0] seg_e, input logic r, input logic [3:0] b);
    @(posedge clk); #1;
    q_b.push_back({an_e, seg_e, 1'b1});
    rst_b = r;
    bin_b = b;
  endtask

  // 12-cycle frame: 0-3 units, 4-5 gap, 6-9 tens, 10-11 gap; bin=b1 before idx 7, b2 from idx 7
  task automatic frame_a(input int show, input logic [3:0] b1, input logic [3:0] b2,
                         input logic rst_last, input int ncyc);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    for (int i = 0; i < ncyc; i++) begin
      if (i < 4) begin
        an_e = 4'b1110; seg_e = ENC[show % 10];
      end else if (i >= 6 && i < 10) begin
        tens_exp(show, an_e, seg_e);
      end else begin
        an_e = 4'b1111; seg_e = 7'b1111111;
      end
      cyc_a(an_e, seg_e, rst_last && (i == ncyc - 1), (i < 7) ? b1 : b2);
    end
  endtask

  // 8-cycle frame without gaps: 0-3 units, 4-7 tens
  task automatic frame_b(input int show, input logic [3:0] b);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        an_e = 4'b1110; seg_e = ENC[show % 10];
      end else begin
        tens_exp(show, an_e, seg_e);
      end
      cyc_b(an_e, seg_e, 1'b0, b);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      checks++;
      if ({an_a, seg_a, dp_a} === e) passes++;
      else $display("FAIL a_cycle%0d: an/seg/dp got %b/%b/%b expected %b/%b/%b",
                    cyc_na, an_a, seg_a, dp_a, e[11:8], e[7:1], e[0]);
      cyc_na++;
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checks++;
      if ({an_b, seg_b, dp_b} === e) passes++;
      else $display("FAIL b_cycle%0d: an/seg/dp got %b/%b/%b expected %b/%b/%b",
                    cyc_nb, an_b, seg_b, dp_b, e[11:8], e[7:1], e[0]);
      cyc_nb++;
    end
  end

  initial begin
    // dut_a: reset timing, value 13, mid-frame changes, reset mid-frame, values 7 and 10
    cyc_a(4'b1110, 7'b1000000, 1'b1, 4'd0);
    frame_a(0, 4'd0, 4'd0, 1'b0, 12);
    frame_a(0, 4'd13, 4'd13, 1'b0, 12);
    frame_a(13, 4'd13, 4'd5, 1'b0, 12);
    frame_a(5, 4'd5, 4'd9, 1'b0, 12);
    frame_a(9, 4'd3, 4'd12, 1'b0, 12);
    frame_a(12, 4'd12, 4'd12, 1'b1, 8);
    frame_a(0, 4'd7, 4'd7, 1'b0, 12);
    frame_a(7, 4'd10, 4'd10, 1'b0, 12);
    frame_a(10, 4'd10, 4'd10, 1'b0, 12);

    // dut_b: first frame shows 0 despite bin=9 during reset, then sweep 0..15
    cyc_b(4'b1110, 7'b1000000, 1'b1, 4'd9);
    frame_b(0, 4'd0);
    for (int v = 1; v < 16; v++) frame_b(v - 1, 4'(v));
    frame_b(15, 4'd15);

    for (int k = 0; k < 4 && (q_a.size() > 0 || q_b.size() > 0); k++) @(posedge clk);
    @(posedge clk);
    if (q_a.size() > 0 || q_b.size() > 0) begin
      checks++;
      $display("FAIL drain: pending got %0d expected 0", q_a.size() + q_b.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
